// File: rtl/rtr_fb_pkg.sv
// Shared types and sizing helpers for the shared-pool flit buffer.
// The RTR_FB_BYPASS_EN macro (empty-VC bypass) is consumed by rtr_flit_buffer_shared.
package rtr_fb_pkg;

  localparam int FB_SLOT_W = 16;

  typedef logic [FB_SLOT_W-1:0] fb_slot_t;
  typedef logic [FB_SLOT_W:0]   fb_count_t;

  function automatic int clogb(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int shared_pool_size(input int buffer_size, input int num_vcs,
                                          input int reserved_per_vc);
    return buffer_size - num_vcs * reserved_per_vc;
  endfunction

endpackage

// File: rtl/rtr_fb_free_list.sv
// Free-slot index FIFO: comes out of reset holding every slot in ascending order.
// One allocation and one release per cycle; a released slot is visible the cycle after.
module rtr_fb_free_list
  import rtr_fb_pkg::*;
#(
  parameter int depth = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     alloc_en,
  output fb_slot_t alloc_slot,
  input  logic     free_en,
  input  fb_slot_t free_slot
);

  localparam int PTR_W = clogb(depth);

  fb_slot_t         fifo [depth];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign alloc_slot = fifo[rd_ptr];

  // Full at reset: rd_ptr == wr_ptr, entries pre-loaded with their own index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < depth; i++) fifo[i] <= fb_slot_t'(i);
    end else begin
      if (alloc_en) rd_ptr <= (rd_ptr == PTR_W'(depth - 1)) ? '0 : rd_ptr + 1'b1;
      if (free_en) begin
        fifo[wr_ptr] <= free_slot;
        wr_ptr       <= (wr_ptr == PTR_W'(depth - 1)) ? '0 : wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtr_flit_buffer_shared.sv
// Input-port flit buffer: per-VC linked lists over a shared slot pool with per-VC reservations.
// Define RTR_FB_BYPASS_EN to forward a push straight to pop_data when popping the same empty VC.
module rtr_flit_buffer_shared
  import rtr_fb_pkg::*;
#(
  parameter int num_vcs         = 4,
  parameter int buffer_size     = 32,
  parameter int reserved_per_vc = 2,
  parameter int flit_data_width = 64
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         push_valid,
  input  logic                                         push_tail,
  input  logic [num_vcs-1:0]                           push_sel_ivc,
  input  logic [flit_data_width-1:0]                   push_data,
  input  logic                                         pop_valid,
  input  logic [num_vcs-1:0]                           pop_sel_ivc,
  output logic [flit_data_width-1:0]                   pop_data,
  output logic [num_vcs-1:0]                           pop_tail_ivc,
  output logic [num_vcs-1:0]                           empty_ivc,
  output logic [num_vcs-1:0]                           almost_empty_ivc,
  output logic [num_vcs-1:0]                           space_ivc,
  output logic [num_vcs-1:0]                           credit_ivc,
  output logic [num_vcs*clogb(buffer_size+1)-1:0]      occupancy_ivc,
  output logic [clogb(buffer_size+1)-1:0]              shared_used,
  output logic [2*num_vcs-1:0]                         errors_ivc
);

  localparam int        CNT_W  = clogb(buffer_size + 1);
  localparam int        IDX_W  = clogb(buffer_size);
  localparam int        VC_W   = clogb(num_vcs);
  localparam fb_count_t RES_C  = fb_count_t'(reserved_per_vc);
  localparam fb_count_t POOL_C = fb_count_t'(shared_pool_size(buffer_size, num_vcs,
                                                              reserved_per_vc));

  logic [flit_data_width-1:0] slot_data [buffer_size];
  logic                       slot_tail [buffer_size];
  fb_slot_t                   next_ptr  [buffer_size];

  fb_slot_t  head_q [num_vcs];
  fb_slot_t  tail_q [num_vcs];
  fb_count_t occ_q  [num_vcs];
  fb_count_t shared_q;
  fb_count_t shared_nxt;

  logic [VC_W-1:0]      push_vc, pop_vc;
  logic                 push_req, pop_req, same_vc, bypass;
  logic                 push_store, pop_store, pop_any;
  logic [num_vcs-1:0]   push_hit, pop_hit, pop_take;
  logic [2*num_vcs-1:0] err_c;
  fb_slot_t             alloc_slot;

  always_comb begin
    push_vc = '0;
    pop_vc  = '0;
    for (int v = 0; v < num_vcs; v++) begin
      if (push_sel_ivc[v]) push_vc = VC_W'(v);
      if (pop_sel_ivc[v])  pop_vc  = VC_W'(v);
    end
  end

  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      space_ivc[v]                    = (occ_q[v] < RES_C) || (shared_q < POOL_C);
      empty_ivc[v]                    = (occ_q[v] == '0);
      almost_empty_ivc[v]             = (occ_q[v] == fb_count_t'(1));
      pop_tail_ivc[v]                 = (occ_q[v] != '0) && slot_tail[head_q[v][IDX_W-1:0]];
      occupancy_ivc[v*CNT_W +: CNT_W] = occ_q[v][CNT_W-1:0];
    end
  end

  // Accept decisions all use pre-pop counts
  always_comb begin
    push_req = push_valid && (push_sel_ivc != '0);
    pop_req  = pop_valid && (pop_sel_ivc != '0);
    same_vc  = (push_vc == pop_vc);
`ifdef RTR_FB_BYPASS_EN
    bypass   = push_req && pop_req && same_vc && (occ_q[pop_vc] == '0);
`else
    bypass   = 1'b0;
`endif
    push_store = push_req && space_ivc[push_vc] && !bypass;
    pop_store  = pop_req && (occ_q[pop_vc] != '0);
    pop_any    = pop_store || bypass;
    for (int v = 0; v < num_vcs; v++) begin
      push_hit[v]   = push_store && (push_vc == VC_W'(v));
      pop_hit[v]    = pop_store && (pop_vc == VC_W'(v));
      pop_take[v]   = pop_any && (pop_vc == VC_W'(v));
      err_c[2*v]    = push_req && (push_vc == VC_W'(v)) && !space_ivc[v] && !bypass;
      err_c[2*v+1]  = pop_req && (pop_vc == VC_W'(v)) && (occ_q[v] == '0) && !bypass;
    end
  end

  // shared_used tracks sum(max(0, occ - reserved)); same-VC push+pop nets to zero
  always_comb begin
    shared_nxt = shared_q;
    if (push_store && !(pop_store && same_vc) && (occ_q[push_vc] >= RES_C))
      shared_nxt = shared_nxt + 1'b1;
    if (pop_store && !(push_store && same_vc) && (occ_q[pop_vc] > RES_C))
      shared_nxt = shared_nxt - 1'b1;
  end

  assign errors_ivc  = reset ? err_c : '0;
  assign shared_used = shared_q[CNT_W-1:0];

  rtr_fb_free_list #(
    .depth (buffer_size)
  ) u_free_list (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (push_store),
    .alloc_slot (alloc_slot),
    .free_en    (pop_store),
    .free_slot  (head_q[pop_vc])
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shared_q   <= '0;
      credit_ivc <= '0;
      pop_data   <= '0;
      for (int v = 0; v < num_vcs; v++) begin
        occ_q[v]  <= '0;
        head_q[v] <= '0;
        tail_q[v] <= '0;
      end
    end else begin
      shared_q   <= shared_nxt;
      credit_ivc <= pop_take;
      if (pop_any) pop_data <= bypass ? push_data : slot_data[head_q[pop_vc][IDX_W-1:0]];
      for (int v = 0; v < num_vcs; v++) begin
        if (push_hit[v] && !pop_hit[v])      occ_q[v] <= occ_q[v] + 1'b1;
        else if (pop_hit[v] && !push_hit[v]) occ_q[v] <= occ_q[v] - 1'b1;
        if (pop_hit[v]) head_q[v] <= next_ptr[head_q[v][IDX_W-1:0]];
        // A push becomes the head when the list is (or is about to become) empty
        if (push_hit[v]) begin
          tail_q[v] <= alloc_slot;
          if ((occ_q[v] == '0) || ((occ_q[v] == fb_count_t'(1)) && pop_hit[v]))
            head_q[v] <= alloc_slot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) begin
      slot_data[alloc_slot[IDX_W-1:0]] <= push_data;
      slot_tail[alloc_slot[IDX_W-1:0]] <= push_tail;
      if (occ_q[push_vc] != '0) next_ptr[tail_q[push_vc][IDX_W-1:0]] <= alloc_slot;
    end
  end

endmodule

// File: tb/tb_rtr_flit_buffer_shared.sv
// Scoreboard bench for rtr_flit_buffer_shared: 2 VCs, 8 slots, 2 reserved per VC (pool of 4).
// Expectations follow the default build or RTR_FB_BYPASS_EN when that macro is defined.
module tb_rtr_flit_buffer_shared;

  localparam int NV  = 2;
  localparam int BS  = 8;
  localparam int RPV = 2;
  localparam int DW  = 64;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_tail = 1'b0;
  logic [NV-1:0] push_sel_ivc = '0;
  logic [DW-1:0] push_data = '0;
  logic          pop_valid = 1'b0;
  logic [NV-1:0] pop_sel_ivc = '0;
  logic [DW-1:0] pop_data;
  logic [NV-1:0] pop_tail_ivc, empty_ivc, almost_empty_ivc, space_ivc, credit_ivc;
  logic [NV*CW-1:0] occupancy_ivc;
  logic [CW-1:0]    shared_used;
  logic [2*NV-1:0]  errors_ivc;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          vc;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rtr_flit_buffer_shared #(
    .num_vcs         (NV),
    .buffer_size     (BS),
    .reserved_per_vc (RPV),
    .flit_data_width (DW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .push_valid       (push_valid),
    .push_tail        (push_tail),
    .push_sel_ivc     (push_sel_ivc),
    .push_data        (push_data),
    .pop_valid        (pop_valid),
    .pop_sel_ivc      (pop_sel_ivc),
    .pop_data         (pop_data),
    .pop_tail_ivc     (pop_tail_ivc),
    .empty_ivc        (empty_ivc),
    .almost_empty_ivc (almost_empty_ivc),
    .space_ivc        (space_ivc),
    .credit_ivc       (credit_ivc),
    .occupancy_ivc    (occupancy_ivc),
    .shared_used      (shared_used),
    .errors_ivc       (errors_ivc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] occ(input int v);
    return 64'(occupancy_ivc[v*CW +: CW]);
  endfunction

  // Monitor: every credit pulse must match the oldest outstanding pop
  always @(negedge clk) begin
    exp_t e;
    if (credit_ivc != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_credit", 64'(credit_ivc), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("credit_ivc", 64'(credit_ivc), 64'(2'b01 << e.vc));
        check("pop_data", pop_data, e.data);
      end
    end
  end

  task automatic step(input logic pv, input logic pt, input logic [1:0] ps,
                      input logic [63:0] pd, input logic qv, input logic [1:0] qs,
                      input logic [3:0] err);
    push_valid   = pv;
    push_tail    = pt;
    push_sel_ivc = ps;
    push_data    = pd;
    pop_valid    = qv;
    pop_sel_ivc  = qs;
    @(negedge clk);
    check("errors_ivc", 64'(errors_ivc), 64'(err));
    @(posedge clk);
    #1;
    push_valid   = 1'b0;
    push_tail    = 1'b0;
    push_sel_ivc = '0;
    pop_valid    = 1'b0;
    pop_sel_ivc  = '0;
  endtask

  task automatic push(input int vc, input logic [63:0] data, input logic tail,
                      input logic [3:0] err);
    logic [1:0] sel;
    sel = 2'b01 << vc;
    step(1'b1, tail, sel, data, 1'b0, 2'b00, err);
  endtask

  task automatic pop(input int vc, input logic [63:0] data);
    logic [1:0] sel;
    sel = 2'b01 << vc;
    exp_q.push_back('{vc, data});
    step(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, sel, 4'b0000);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 64'h0, 1'b0, 2'b00, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_occupancy", 64'(occupancy_ivc), 64'h0);
    check("rst_shared", 64'(shared_used), 64'h0);
    check("rst_empty", 64'(empty_ivc), 64'h3);
    check("rst_credit", 64'(credit_ivc), 64'h0);
    check("rst_errors", 64'(errors_ivc), 64'h0);
    check("rst_pop_data", pop_data, 64'h0);
    check("rst_space", 64'(space_ivc), 64'h3);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill VC0 into the shared pool, then overflow
    for (int i = 0; i < 6; i++) push(0, 64'h100 + 64'(i), (i == 5), 4'b0000);
    check("fill_occ0", occ(0), 64'd6);
    check("fill_shared", 64'(shared_used), 64'd4);
    check("fill_space", 64'(space_ivc), 64'h2);
    check("fill_empty", 64'(empty_ivc), 64'h2);
    check("fill_pop_tail", 64'(pop_tail_ivc), 64'h0);
    push(0, 64'h1FF, 1'b1, 4'b0001);
    check("ovf_occ0", occ(0), 64'd6);

    // VC1 still gets its reservation
    push(1, 64'h200, 1'b1, 4'b0000);
    push(1, 64'h201, 1'b1, 4'b0000);
    push(1, 64'h2FF, 1'b0, 4'b0100);
    check("vc1_occ", occ(1), 64'd2);
    check("vc1_space", 64'(space_ivc), 64'h0);
    check("vc1_pop_tail", 64'(pop_tail_ivc), 64'h2);

    for (int i = 0; i < 4; i++) pop(0, 64'h100 + 64'(i));
    check("drain_shared", 64'(shared_used), 64'd0);
    check("drain_occ0", occ(0), 64'd2);
    pop(0, 64'h104);
    check("almost_empty", 64'(almost_empty_ivc), 64'h1);
    check("head_tail_bits", 64'(pop_tail_ivc), 64'h3);
    pop(0, 64'h105);
    pop(1, 64'h200);
    pop(1, 64'h201);
    idle();
    check("drained_empty", 64'(empty_ivc), 64'h3);

    // Interleaved VCs, cross-VC push+pop, same-VC push+pop
    push(0, 64'hA0, 1'b0, 4'b0000);
    push(1, 64'hB0, 1'b0, 4'b0000);
    push(0, 64'hA1, 1'b0, 4'b0000);
    exp_q.push_back('{0, 64'hA0});
    step(1'b1, 1'b0, 2'b10, 64'hB1, 1'b1, 2'b01, 4'b0000);
    pop(1, 64'hB0);
    exp_q.push_back('{0, 64'hA1});
    step(1'b1, 1'b1, 2'b01, 64'hA2, 1'b1, 2'b01, 4'b0000);
    check("same_vc_occ0", occ(0), 64'd1);
    pop(1, 64'hB1);
    pop(0, 64'hA2);
    idle();
    check("inter_occupancy", 64'(occupancy_ivc), 64'h0);
    check("inter_shared", 64'(shared_used), 64'h0);

    // Underflow, then push+pop on the same empty VC
    step(1'b0, 1'b0, 2'b00, 64'h0, 1'b1, 2'b10, 4'b1000);
`ifdef RTR_FB_BYPASS_EN
    exp_q.push_back('{0, 64'hC0});
    step(1'b1, 1'b0, 2'b01, 64'hC0, 1'b1, 2'b01, 4'b0000);
    check("bypass_occ0", occ(0), 64'd0);
    idle();
`else
    step(1'b1, 1'b0, 2'b01, 64'hC0, 1'b1, 2'b01, 4'b0010);
    check("nobypass_occ0", occ(0), 64'd1);
    pop(0, 64'hC0);
    idle();
`endif

    // Reset mid-stream discards everything
    for (int i = 0; i < 5; i++) push(0, 64'h300 + 64'(i), 1'b0, 4'b0000);
    check("pre_reset_shared", 64'(shared_used), 64'd3);
    reset = 1'b0;
    #1;
    check("mid_rst_occupancy", 64'(occupancy_ivc), 64'h0);
    check("mid_rst_shared", 64'(shared_used), 64'h0);
    check("mid_rst_empty", 64'(empty_ivc), 64'h3);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_credit", 64'(credit_ivc), 64'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // All 8 slots usable again
    for (int i = 0; i < 4; i++) push(0, 64'h400 + 64'(i), 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) push(1, 64'h500 + 64'(i), 1'b0, 4'b0000);
    check("refill_occ0", occ(0), 64'd4);
    check("refill_occ1", occ(1), 64'd4);
    check("refill_shared", 64'(shared_used), 64'd4);
    push(1, 64'h5FF, 1'b0, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      pop(0, 64'h400 + 64'(i));
      pop(1, 64'h500 + 64'(i));
    end
    idle();
    idle();
    check("final_occupancy", 64'(occupancy_ivc), 64'h0);
    check("final_shared", 64'(shared_used), 64'h0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
